// File: rtl/datamem_pkg.sv
// Shared constants and helpers for the byte-addressable data memory.
package datamem_pkg;

  localparam int unsigned DATA_MEM_SIZE = 1024;
  localparam int unsigned NUM_LANES     = 8;

  localparam int unsigned XFER_B = 1;
  localparam int unsigned XFER_H = 2;
  localparam int unsigned XFER_W = 4;
  localparam int unsigned XFER_D = 8;

  function automatic logic size_valid(input logic [3:0] sz);
    return (sz == 4'(XFER_B)) || (sz == 4'(XFER_H)) ||
           (sz == 4'(XFER_W)) || (sz == 4'(XFER_D));
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [3:0] sz);
    logic [2:0] m;
    m = 3'b000;
    if (size_valid(sz)) m = 3'(sz - 4'd1);
    return m;
  endfunction

endpackage

// File: rtl/datamem_lane_sel.sv
// Maps a transfer base address and size onto byte enables and per-lane memory indices.
// Lane i carries read_data/write_data bits [8i+7:8i]; lane 0 is the LSB (highest address).
module datamem_lane_sel
  import datamem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                           enable,
  input  logic [ADDR_BITS-1:0]           base,
  input  logic [3:0]                     xfer_size,
  output logic [NUM_LANES-1:0]           byte_en,
  output logic [NUM_LANES*ADDR_BITS-1:0] lane_addr
);

  always_comb begin
    byte_en   = '0;
    lane_addr = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (enable && (4'(i) < xfer_size)) begin
        byte_en[i] = 1'b1;
        // Big-endian: lane 0 maps to the last byte of the transfer.
        lane_addr[i*ADDR_BITS +: ADDR_BITS] =
          base + ADDR_BITS'(xfer_size) - ADDR_BITS'(i) - ADDR_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable big-endian data memory: combinational read, synchronous 1/2/4/8-byte write.
// Define DATAMEM_ALIGN_CHECK_EN to reject misaligned accesses instead of aligning them down.
module data_memory
  import datamem_pkg::*;
#(
  parameter int unsigned DATA_MEM_SIZE = datamem_pkg::DATA_MEM_SIZE,
  parameter int unsigned ADDR_W        = 64,
  parameter int unsigned DATA_W        = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              write_enable,
  input  logic              read_enable,
  input  logic [DATA_W-1:0] write_data,
  input  logic [3:0]        xfer_size,
  output logic [DATA_W-1:0] read_data
);

  localparam int unsigned AW = $clog2(DATA_MEM_SIZE);

  logic [7:0]                mem [DATA_MEM_SIZE];
  logic [AW-1:0]             ea;
  logic [AW-1:0]             mask_ext;
  logic [AW-1:0]             base;
  logic                      size_ok;
  logic                      access_ok;
  logic [NUM_LANES-1:0]      byte_en;
  logic [NUM_LANES*AW-1:0]   lane_addr;
  logic                      unused_addr;

  assign ea          = address[AW-1:0];
  assign unused_addr = ^address[ADDR_W-1:AW];
  assign size_ok     = size_valid(xfer_size);
  assign mask_ext    = AW'(align_mask(xfer_size));

`ifdef DATAMEM_ALIGN_CHECK_EN
  logic misalign;
  assign misalign  = |(ea & mask_ext);
  assign base      = ea;
  assign access_ok = size_ok && !misalign;

  always_ff @(posedge clk) begin
    if (!reset && (write_enable || read_enable) && size_ok) begin
      assert (!misalign)
        else $error("data_memory: misaligned access address=%h size=%0d", address, xfer_size);
    end
  end
`else
  // Misaligned accesses silently round down to the natural boundary.
  assign base      = ea & ~mask_ext;
  assign access_ok = size_ok;
`endif

  datamem_lane_sel #(
    .ADDR_BITS (AW)
  ) u_lane_sel (
    .enable    (access_ok),
    .base      (base),
    .xfer_size (xfer_size),
    .byte_en   (byte_en),
    .lane_addr (lane_addr)
  );

  // Storage update; reset clears every byte and takes priority over a store.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned j = 0; j < DATA_MEM_SIZE; j++) begin
        mem[j] <= 8'h00;
      end
    end else if (write_enable) begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        if (byte_en[i]) begin
          mem[lane_addr[i*AW +: AW]] <= write_data[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    read_data = '0;
    if (read_enable) begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        if (byte_en[i]) begin
          read_data[8*i +: 8] = mem[lane_addr[i*AW +: AW]];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: expected load values queued at drive time, popped at sample time.
module tb_data_memory;

  logic        clk;
  logic        reset;
  logic [63:0] address;
  logic        write_enable;
  logic        read_enable;
  logic [63:0] write_data;
  logic [3:0]  xfer_size;
  logic [63:0] read_data;

  int unsigned checks;
  int unsigned errors;
  logic [63:0] exp_q[$];

  data_memory dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .write_data   (write_data),
    .xfer_size    (xfer_size),
    .read_data    (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic compare(input string tag);
    logic [63:0] obs;
    logic [63:0] e;
    obs = read_data;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%h expected=<queued value>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e)
        else begin
          errors++;
          $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    end
  endtask

  task automatic rd(input logic [63:0] a, input logic [3:0] sz, input logic [63:0] e,
                    input string tag);
    @(negedge clk);
    address      = a;
    xfer_size    = sz;
    read_enable  = 1'b1;
    write_enable = 1'b0;
    exp_q.push_back(e);
    #1;
    compare(tag);
  endtask

  task automatic wr(input logic [63:0] a, input logic [3:0] sz, input logic [63:0] d);
    @(negedge clk);
    address      = a;
    xfer_size    = sz;
    write_data   = d;
    write_enable = 1'b1;
    read_enable  = 1'b0;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    address      = '0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    write_data   = '0;
    xfer_size    = 4'd8;

    // Reset clears memory
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd(64'd0,    4'd8, 64'd0, "reset_at0");
    rd(64'd1016, 4'd8, 64'd0, "reset_at1016");

    // Doubleword store and big-endian byte placement
    wr(64'd128, 4'd8, 64'd69);
    rd(64'd128, 4'd8, 64'd69,  "dword_128");
    rd(64'd135, 4'd1, 64'h45,  "byte_135");
    rd(64'd128, 4'd1, 64'h00,  "byte_128");

    // Narrow loads out of a doubleword
    wr(64'd8, 4'd8, 64'h1122334455667788);
    rd(64'd8,  4'd8, 64'h1122334455667788, "dword_8");
    rd(64'd8,  4'd4, 64'h11223344,         "word_8");
    rd(64'd14, 4'd2, 64'h7788,             "half_14");
    rd(64'd9,  4'd1, 64'h22,               "byte_9");

    // Halfword store only touches two bytes
    wr(64'd16, 4'd2, 64'hFFFF_FFFF_FFFF_ABCD);
    rd(64'd16, 4'd8, 64'hABCD_0000_0000_0000, "half_store_16");

    // Top-of-memory boundary
    wr(64'd1016, 4'd8, 64'hA1A2A3A4A5A6A7A8);
    rd(64'd1016, 4'd8, 64'hA1A2A3A4A5A6A7A8, "dword_1016");
    rd(64'd1023, 4'd1, 64'hA8,               "byte_1023");

    // Read-during-write shows old data until the edge
    @(negedge clk);
    address      = 64'd128;
    xfer_size    = 4'd8;
    write_data   = 64'hCAFEF00DDEADBEEF;
    write_enable = 1'b1;
    read_enable  = 1'b1;
    exp_q.push_back(64'd69);
    #1;
    compare("rdw_old");
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    exp_q.push_back(64'hCAFEF00DDEADBEEF);
    compare("rdw_new");

    // Reset beats a simultaneous write
    @(negedge clk);
    reset        = 1'b1;
    address      = 64'd128;
    xfer_size    = 4'd8;
    write_data   = 64'd69;
    write_enable = 1'b1;
    read_enable  = 1'b0;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    write_enable = 1'b0;
    rd(64'd128, 4'd8, 64'd0, "reset_beats_write");
    rd(64'd8,   4'd8, 64'd0, "reset_clears_8");

    // read_enable low forces zero
    wr(64'd24, 4'd8, 64'h0F0E0D0C0B0A0908);
    @(negedge clk);
    address     = 64'd24;
    xfer_size   = 4'd8;
    read_enable = 1'b0;
    exp_q.push_back(64'd0);
    #1;
    compare("read_disabled");
    rd(64'd24, 4'd8, 64'h0F0E0D0C0B0A0908, "read_enabled");

    // Upper address bits alias
    wr(64'd1024 + 64'd128, 4'd8, 64'h0102030405060708);
    rd(64'd128,            4'd8, 64'h0102030405060708, "alias_128");
    rd(64'hFFFF_0000_0000_0080, 4'd8, 64'h0102030405060708, "alias_high");

    // Illegal sizes: store dropped and load reads zero
    wr(64'd200, 4'd3, 64'hFFFFFFFFFFFFFFFF);
    wr(64'd200, 4'd0, 64'hFFFFFFFFFFFFFFFF);
    rd(64'd200, 4'd8, 64'd0, "illegal_write_dropped");
    rd(64'd128, 4'd3, 64'd0, "illegal_read_zero");
    rd(64'd128, 4'd9, 64'd0, "illegal_read_nine");

`ifndef DATAMEM_ALIGN_CHECK_EN
    // Misaligned accesses round down to the natural boundary
    wr(64'd130, 4'd4, 64'h00000000DEADBEEF);
    rd(64'd128, 4'd8, 64'hDEADBEEF05060708, "misalign_write_128");
    rd(64'd131, 4'd4, 64'hDEADBEEF,         "misalign_read_131");
    rd(64'd133, 4'd2, 64'h0506,             "misalign_half_133");
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
